// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM state
// encoding, default geometry/latency and the latency counter width.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_LATENCY    = 4;

  // Wide enough for LATENCY values 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// Word storage for the instruction memory: synchronous write, combinational
// read by word index. Contents are never reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] widx,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] ridx,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Commit a write at the clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/imem_responder.sv
// Responder side of the instruction-fetch memory interface. Reads complete
// after a fixed LATENCY with a one-cycle done pulse; writes complete in one
// cycle. stall is high whenever the FSM is not IDLE and requests are ignored
// while it is. Bad requests (read+write together, or odd address) give a
// one-cycle err pulse instead of done.
//
// Handshake: a request is accepted at a clock edge only when stall is low in
// the cycle before that edge; the result (done or err) is a single-cycle
// pulse, and the next request may be accepted in the first cycle stall is low
// again.
//
// Optional macro IMEM_LINEBUF_EN: a one-entry buffer of the last completed
// read; a read hitting it completes in the cycle after acceptance.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              stall,
  output logic              err,
  output state_t            dbg_state
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DEPTH_LOG2-1:0]   widx;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DATA_W-1:0]       arr_rdata;
  logic                    req_bad;
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    mem_we;
  logic                    fill;
  logic                    lb_hit;
  logic [DATA_W-1:0]       lb_word;
  logic                    addr_hi_unused;

  // Upper address bits wrap and are intentionally ignored.
  assign addr_hi_unused = ^addr;

  assign widx    = addr[DEPTH_LOG2:1];
  assign req_bad = (rd_req & wr_req) | ((rd_req | wr_req) & addr[0]);
  assign wr_ok   = (state == IDLE) & wr_req & ~rd_req & ~addr[0];
  assign rd_ok   = (state == IDLE) & rd_req & ~wr_req & ~addr[0];
  assign mem_we  = wr_ok & ~rst;

  // In IDLE the array looks at the incoming address (LATENCY==1 path);
  // otherwise at the index latched on acceptance.
  assign rd_idx  = (state == IDLE) ? widx : idx_q;

  // A read is completing from storage on this edge.
  assign fill = ~rst & (((state == BUSY) & (cnt == CNT_W'(1))) |
                        (rd_ok & ~lb_hit & (LATENCY == 1)));

  assign stall     = (state != IDLE);
  assign dbg_state = state;

  imem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .widx  (widx),
    .wdata (wr_data),
    .ridx  (rd_idx),
    .rdata (arr_rdata)
  );

`ifdef IMEM_LINEBUF_EN
  logic                  lb_valid;
  logic [DEPTH_LOG2-1:0] lb_idx;
  logic [DATA_W-1:0]     lb_data;

  assign lb_hit  = lb_valid && (lb_idx == widx);
  assign lb_word = lb_data;

  // Track the last completed storage read; a write to that word invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_valid <= 1'b0;
      lb_idx   <= '0;
      lb_data  <= '0;
    end else if (mem_we && (lb_idx == widx)) begin
      lb_valid <= 1'b0;
    end else if (fill) begin
      lb_valid <= 1'b1;
      lb_idx   <= rd_idx;
      lb_data  <= arr_rdata;
    end
  end
`else
  assign lb_hit  = 1'b0;
  assign lb_word = '0;
`endif

  // Main FSM: acceptance, latency countdown, done/err pulses and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      data_out <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_bad) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (wr_req) begin
            state <= RESP;
            done  <= 1'b1;
          end else if (rd_req) begin
            idx_q <= widx;
            if (lb_hit) begin
              state    <= RESP;
              done     <= 1'b1;
              data_out <= lb_word;
            end else if (LATENCY > 1) begin
              cnt   <= LAT_M1;
              state <= BUSY;
            end else begin
              state    <= RESP;
              done     <= 1'b1;
              data_out <= arr_rdata;
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state    <= RESP;
            done     <= 1'b1;
            data_out <= arr_rdata;
            cnt      <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_rd_ok;
  assign unused_rd_ok = rd_ok;

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder. Directed transactions push the expected
// response (kind, completion cycle, data_out) into a queue; a monitor pops
// and compares whenever done or err pulses.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req;
  logic              wr_req;
  logic [15:0]       addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              stall;
  logic              err;
  state_t            dbg_state;

  imem_responder #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LATENCY    (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr      (addr),
    .wr_data   (wr_data),
    .data_out  (data_out),
    .done      (done),
    .stall     (stall),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  // Entry: {kind[1:0] (10=done, 01=err), cycle[15:0], data_out[15:0]}
  logic [33:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Transaction-level reference state.
  logic [15:0] mem_m [1024];
  logic [15:0] cur_data;
  bit          lb_v;
  logic [9:0]  lb_i;
  logic [15:0] lb_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [33:0] mon_e;
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_response: done=%0b err=%0b at cycle %0d, none expected",
                 done, err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_kind", {30'd0, done, err}, {30'd0, mon_e[33:32]});
        check("resp_cycle", {16'd0, cyc}, {16'd0, mon_e[31:16]});
        check("data_out", {16'd0, data_out}, {16'd0, mon_e[15:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one request in the first cycle stall is low, then record the
  // expected response. Returns just after the acceptance edge.
  task automatic issue(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d);
    logic [9:0]  ix;
    logic [15:0] rv;
    int          lat;
    bit          hit;
    @(negedge clk);
    for (int i = 0; i < 64 && stall; i++) @(negedge clk);
    check("issue_ready", {31'd0, stall}, 32'd0);
    rd_req  = r;
    wr_req  = w;
    addr    = a;
    wr_data = d;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    ix = a[10:1];
    if ((r && w) || ((r || w) && a[0])) begin
      exp_q.push_back({2'b01, cyc, cur_data});
    end else if (w) begin
      mem_m[ix] = d;
      if (lb_v && lb_i == ix) lb_v = 1'b0;
      exp_q.push_back({2'b10, cyc, cur_data});
    end else if (r) begin
      hit = 1'b0;
`ifdef IMEM_LINEBUF_EN
      hit = lb_v && (lb_i == ix);
`endif
      rv  = hit ? lb_d : mem_m[ix];
      lat = hit ? 1 : LATENCY;
      cur_data = rv;
      lb_v = 1'b1;
      lb_i = ix;
      lb_d = rv;
      exp_q.push_back({2'b10, cyc + 16'(lat - 1), rv});
    end
  endtask

  // Wait (bounded) for every expected response to be seen.
  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    addr     = 16'h0000;
    wr_data  = 16'h0000;
    cur_data = 16'h0000;
    lb_v     = 1'b0;
    lb_i     = '0;
    lb_d     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_data", {16'd0, data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Preload
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    issue(1'b0, 1'b1, 16'h0020, 16'h5A5A);
    issue(1'b0, 1'b1, 16'h07FE, 16'h7E7E);
    issue(1'b0, 1'b1, 16'h0000, 16'h1111);
    drain();

    // Read 0x0010: done in cycle 4, stall high in cycles 1..4
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int j = 1; j <= LATENCY; j++) begin
      @(negedge clk);
      check("stall_busy", {31'd0, stall}, 32'd1);
    end
    @(negedge clk);
    check("stall_idle", {31'd0, stall}, 32'd0);
    drain();

    // Misaligned read -> err, then storage intact
    issue(1'b1, 1'b0, 16'h0011, 16'h0000);
    drain();
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    drain();

    // Read and write together -> err, 0x0020 not written
    issue(1'b1, 1'b1, 16'h0020, 16'hDEAD);
    drain();
    issue(1'b1, 1'b0, 16'h0020, 16'h0000);
    drain();

    // rd_req toggled during BUSY: exactly one done
    issue(1'b1, 1'b0, 16'h07FE, 16'h0000);
    for (int j = 1; j <= LATENCY; j++) begin
      @(negedge clk);
      rd_req = j[0];
    end
    @(negedge clk);
    rd_req = 1'b0;
    drain();
    repeat (6) @(negedge clk);

    // Misaligned write -> err, neighbour word unchanged
    issue(1'b0, 1'b1, 16'h0021, 16'hCAFE);
    drain();
    issue(1'b1, 1'b0, 16'h0020, 16'h0000);
    drain();

    // Address wrap: 0x0800 aliases word 0
    issue(1'b0, 1'b1, 16'h0800, 16'hA0A0);
    drain();
    issue(1'b1, 1'b0, 16'h0000, 16'h0000);
    drain();

    // Reset in cycle 2 of a read drops it
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    cur_data = 16'h0000;
    lb_v     = 1'b0;
    @(negedge clk);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_data", {16'd0, data_out}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    drain();

    // Repeat read (buffer hit when enabled), then write invalidates
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    drain();
    issue(1'b0, 1'b1, 16'h0010, 16'h1234);
    drain();
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    drain();
    repeat (4) @(negedge clk);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder side of the instruction-fetch memory interface: accepts word read requests from a fetch stage and returns data after a fixed multi-cycle latency, with stall/done handshake.
- Also accepts single-cycle word writes for program loading.
- Replaces the ideal zero-latency instruction memory so the pipeline's stall path can be exercised.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH_LOG2, 10, log2 of storage depth in words (1024 words).
- LATENCY, 4, cycles from accepting read edge to done; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req  in  1  read request, sampled only in IDLE
- wr_req  in  1  write request, sampled only in IDLE
- addr  in  16  byte address; word index = addr[DEPTH_LOG2:1]; higher bits ignored (wrap)
- wr_data  in  DATA_W  write data
- data_out  out  DATA_W  registered read data
- done  out  1  one-cycle completion pulse for an accepted read or write
- stall  out  1  high whenever not IDLE; requests ignored while high
- err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state IDLE, data_out 0, done 0, stall 0, err 0, counter 0.
  - Storage contents are not affected by rst.
  - A read of a never-written word returns X; the bench must preload.
- States: IDLE, BUSY, RESP, ERR.
- IDLE transitions:
  - rd_req & wr_req -> ERR.
  - rd_req & addr[0] or wr_req & addr[0] (misaligned) -> ERR.
  - wr_req, aligned: write storage at this edge; go RESP (write flavour, data_out unchanged).
  - rd_req, aligned: latch word index; cnt <= LATENCY-1; go BUSY if LATENCY>1, else RESP.
- BUSY: if cnt==1 -> RESP, else cnt <= cnt-1.
- RESP:
  - done=1 for exactly one cycle.
  - For reads, data_out is updated on the edge entering RESP and holds until the next completed read.
  - Returns to IDLE next edge.
- ERR: err=1 for one cycle, done=0, data_out unchanged; returns to IDLE.
- Latency: a read accepted at edge E shows done high during the cycle after edge E+LATENCY-1. Example for LATENCY=4: accepted at the end of cycle 0, done is high in cycle 4 only.
- stall: combinational from state (state != IDLE). It rises in the cycle after acceptance and covers BUSY, RESP and ERR.
- Back-to-back: the earliest next acceptance is in the IDLE cycle following RESP or ERR.
- Reset mid-operation: any pending read or error is dropped, with no done or err pulse; a write already committed stays written.
- Address wrap: addr 0x0800 with DEPTH_LOG2=10 aliases word 0.

Optional Feature:
- Macro: IMEM_LINEBUF_EN.
- Defined:
  - One-entry buffer holds the word index and data of the last completed read, with a valid bit.
  - An aligned read hitting the buffer goes IDLE -> RESP directly (done in the cycle after acceptance) and returns the buffered data.
  - Valid is cleared by rst and by a write to the same word index.
- Undefined: every read takes LATENCY; no buffer registers exist.

Decomposition:
- Package imem_pkg:
  - state encoding enum (IDLE, BUSY, RESP, ERR);
  - default DATA_W, DEPTH_LOG2 and LATENCY constants;
  - 4-bit counter width constant.
- Sub-module imem_array: 2^DEPTH_LOG2 x DATA_W storage with synchronous write and combinational read by word index.
- FSM, counter and optional line buffer live in imem_responder.

Test Plan:
- Write 0xBEEF at 0x0010, then read 0x0010 with LATENCY=4 -> done high exactly in cycle 4 after acceptance; data_out=0xBEEF; stall high in cycles 1-4.
- Read at 0x0011 -> err pulse in cycle 1; done never rises; data_out unchanged; storage unchanged.
- rd_req and wr_req both high at 0x0020 -> err pulse; 0x0020 contents unchanged on a subsequent read.
- rd_req toggled every cycle during BUSY -> extra requests ignored; exactly one done per accepted read.
- rst asserted in cycle 2 of a read -> no done; state IDLE, stall 0 and data_out 0 next cycle; a new read of 0x0010 still returns 0xBEEF.
- IMEM_LINEBUF_EN: read 0x0010 twice -> second done one cycle after acceptance. Then write 0x1234 to 0x0010 and read again -> full LATENCY, data 0x1234.
